// File: rtl/skp_os_scheduler.sv
// SKP ordered-set scheduler: watches COM/SKP sets in the read_clk stream and
// issues at most one SKP insert or delete command per set, with event counters.
module skp_os_scheduler #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned MAX_SKP    = 5,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  read_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  buffer_mode,
    input  logic                  sym_valid,
    input  logic [DATA_WIDTH-1:0] sym_in,
    input  logic                  add_req,
    input  logic                  delete_req,
    output logic                  insert_cmd,
    output logic                  delete_cmd,
    output logic                  skp_added,
    output logic                  skp_removed,
    output logic                  skp_len_err,
    output logic [CNT_WIDTH-1:0]  add_cnt,
    output logic [CNT_WIDTH-1:0]  del_cnt
);

    localparam int unsigned SKP_CNT_W = $clog2(MAX_SKP + 1);

    localparam logic [DATA_WIDTH-1:0] COM_RDN = DATA_WIDTH'(10'b0011111010);
    localparam logic [DATA_WIDTH-1:0] COM_RDP = DATA_WIDTH'(10'b1100000101);
    localparam logic [DATA_WIDTH-1:0] SKP_RDN = DATA_WIDTH'(10'b0011110100);
    localparam logic [DATA_WIDTH-1:0] SKP_RDP = DATA_WIDTH'(10'b1100001011);

    localparam logic [SKP_CNT_W-1:0] SKP_MAX = SKP_CNT_W'(MAX_SKP);
    localparam logic [SKP_CNT_W-1:0] SKP_ONE = SKP_CNT_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COM_SEEN = 2'd1,
        SKP_RUN  = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic                   pend_add, pend_add_nxt;
    logic                   pend_del, pend_del_nxt;
    logic [SKP_CNT_W-1:0]   skp_cnt, skp_cnt_nxt;
    logic                   ins_c, del_c, err_c;
    logic                   is_com, is_skp;

    assign is_com = (sym_in == COM_RDN) || (sym_in == COM_RDP);
    assign is_skp = (sym_in == SKP_RDN) || (sym_in == SKP_RDP);

    // State and per-set context registers
    always_ff @(posedge read_clk) begin
        if (rst) begin
            state    <= IDLE;
            pend_add <= 1'b0;
            pend_del <= 1'b0;
            skp_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            pend_add <= pend_add_nxt;
            pend_del <= pend_del_nxt;
            skp_cnt  <= skp_cnt_nxt;
        end
    end

    // Next-state: a COM always (re)starts a set and latches the monitor requests
    always_comb begin
        state_nxt    = state;
        pend_add_nxt = pend_add;
        pend_del_nxt = pend_del;
        skp_cnt_nxt  = skp_cnt;
        if (sym_valid) begin
            if (is_com) begin
                state_nxt    = COM_SEEN;
                pend_add_nxt = add_req;
                pend_del_nxt = delete_req;
                skp_cnt_nxt  = '0;
            end else begin
                unique case (state)
                    COM_SEEN: begin
                        if (is_skp) begin
                            state_nxt   = SKP_RUN;
                            skp_cnt_nxt = SKP_ONE;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                    SKP_RUN: begin
                        if (is_skp && skp_cnt != SKP_MAX) begin
                            skp_cnt_nxt = skp_cnt + SKP_ONE;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // Command decode; insert is judged on the symbol that closes the SKP run
    always_comb begin
        ins_c = 1'b0;
        del_c = 1'b0;
        err_c = 1'b0;
        if (sym_valid) begin
            unique case (state)
                COM_SEEN: err_c = !is_skp && !is_com;
                SKP_RUN: begin
                    if (is_skp) begin
                        if (skp_cnt == SKP_MAX) begin
                            err_c = 1'b1;
                        end else begin
                            del_c = (skp_cnt == SKP_ONE) && pend_del && !pend_add && enable;
                        end
                    end else begin
                        ins_c = pend_add && !pend_del && enable && !buffer_mode &&
                                (skp_cnt < SKP_MAX);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered pulses and saturating event counters
    always_ff @(posedge read_clk) begin
        if (rst) begin
            insert_cmd  <= 1'b0;
            delete_cmd  <= 1'b0;
            skp_added   <= 1'b0;
            skp_removed <= 1'b0;
            skp_len_err <= 1'b0;
            add_cnt     <= '0;
            del_cnt     <= '0;
        end else begin
            insert_cmd  <= ins_c;
            delete_cmd  <= del_c;
            skp_added   <= ins_c;
            skp_removed <= del_c;
            skp_len_err <= err_c;
            if (ins_c && add_cnt != CNT_MAX) begin
                add_cnt <= add_cnt + CNT_WIDTH'(1);
            end
            if (del_c && del_cnt != CNT_MAX) begin
                del_cnt <= del_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_skp_os_scheduler.sv
// Scenario bench for skp_os_scheduler: expected pulse vectors are queued as
// symbols are driven and compared against captured outputs after each scenario.
module tb_skp_os_scheduler;

    localparam logic [9:0] COM  = 10'b0011111010;
    localparam logic [9:0] COMN = 10'b1100000101;
    localparam logic [9:0] SKP  = 10'b0011110100;
    localparam logic [9:0] SKPN = 10'b1100001011;
    localparam logic [9:0] DAT  = 10'b0111000011;

    // Expected/observed vector: {insert_cmd, skp_added, delete_cmd, skp_removed, skp_len_err}
    localparam logic [2:0] E_NONE = 3'b000;
    localparam logic [2:0] E_INS  = 3'b100;
    localparam logic [2:0] E_DEL  = 3'b010;
    localparam logic [2:0] E_ERR  = 3'b001;

    logic       read_clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       buffer_mode = 1'b0;
    logic       sym_valid = 1'b0;
    logic [9:0] sym_in = '0;
    logic       add_req = 1'b0;
    logic       delete_req = 1'b0;
    logic       insert_cmd, delete_cmd, skp_added, skp_removed, skp_len_err;
    logic [7:0] add_cnt, del_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_add = '0;
    logic [7:0] exp_del = '0;
    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];
    logic [4:0] e_v, o_v;

    skp_os_scheduler dut (
        .read_clk    (read_clk),
        .rst         (rst),
        .enable      (enable),
        .buffer_mode (buffer_mode),
        .sym_valid   (sym_valid),
        .sym_in      (sym_in),
        .add_req     (add_req),
        .delete_req  (delete_req),
        .insert_cmd  (insert_cmd),
        .delete_cmd  (delete_cmd),
        .skp_added   (skp_added),
        .skp_removed (skp_removed),
        .skp_len_err (skp_len_err),
        .add_cnt     (add_cnt),
        .del_cnt     (del_cnt)
    );

    always #5 read_clk = ~read_clk;

    // One symbol cycle: drive, record the expected pulses, capture the registered result
    task automatic drive_sym(input logic v, input logic [9:0] s, input logic a,
                             input logic d, input logic r, input logic [2:0] e);
        logic [2:0] ee;
        @(negedge read_clk);
        sym_valid  = v;
        sym_in     = s;
        add_req    = a;
        delete_req = d;
        rst        = r;
        ee = r ? E_NONE : e;
        exp_q.push_back({ee[2], ee[2], ee[1], ee[1], ee[0]});
        if (r) begin
            exp_add = '0;
            exp_del = '0;
        end else begin
            if (ee[2] && exp_add != 8'hFF) exp_add = exp_add + 8'd1;
            if (ee[1] && exp_del != 8'hFF) exp_del = exp_del + 8'd1;
        end
        @(posedge read_clk);
        #1;
        obs_q.push_back({insert_cmd, skp_added, delete_cmd, skp_removed, skp_len_err});
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_sym(1'b1, COM, 1'b1, 1'b1, 1'b1, E_NONE);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b1, E_NONE);
        checks++;
        if ({insert_cmd, delete_cmd, skp_added, skp_removed, skp_len_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses: observed %b expected 00000",
                     {insert_cmd, delete_cmd, skp_added, skp_removed, skp_len_err});
        end
        checks++;
        if (add_cnt !== 8'd0 || del_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_counts: observed add=%0d del=%0d expected 0/0", add_cnt, del_cnt);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_delete();
        drive_sym(1'b1, COM,  1'b0, 1'b1, 1'b0, E_NONE);
        drive_sym(1'b1, SKP,  1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, SKPN, 1'b0, 1'b0, 1'b0, E_DEL);
        drive_sym(1'b1, SKP,  1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, DAT,  1'b0, 1'b0, 1'b0, E_NONE);
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front(); o_v = obs_q.pop_front(); checks++;
            if (o_v !== e_v) begin
                errors++; $display("FAIL delete_seq: observed %b expected %b", o_v, e_v);
            end
        end
        checks++;
        if (del_cnt !== 8'd1) begin
            errors++; $display("FAIL delete_cnt: observed %0d expected 1", del_cnt);
        end
    endtask

    task automatic test_insert();
        drive_sym(1'b1, COMN, 1'b1, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, SKP,  1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, DAT,  1'b0, 1'b0, 1'b0, E_INS);
        buffer_mode = 1'b1;
        drive_sym(1'b1, COM,  1'b1, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, SKP,  1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, DAT,  1'b0, 1'b0, 1'b0, E_NONE);
        buffer_mode = 1'b0;
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front(); o_v = obs_q.pop_front(); checks++;
            if (o_v !== e_v) begin
                errors++; $display("FAIL insert_seq: observed %b expected %b", o_v, e_v);
            end
        end
        checks++;
        if (add_cnt !== 8'd1) begin
            errors++; $display("FAIL insert_cnt: observed %0d expected 1", add_cnt);
        end
    endtask

    task automatic test_length();
        drive_sym(1'b1, COM, 1'b1, 1'b0, 1'b0, E_NONE);
        for (int i = 0; i < 5; i++) drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, DAT, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, COM, 1'b1, 1'b0, 1'b0, E_NONE);
        for (int i = 0; i < 5; i++) drive_sym(1'b1, SKPN, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b0, E_ERR);
        drive_sym(1'b1, DAT, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, COM, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, DAT, 1'b0, 1'b0, 1'b0, E_ERR);
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front(); o_v = obs_q.pop_front(); checks++;
            if (o_v !== e_v) begin
                errors++; $display("FAIL length_seq: observed %b expected %b", o_v, e_v);
            end
        end
    endtask

    task automatic test_conflict();
        drive_sym(1'b1, COM, 1'b1, 1'b1, 1'b0, E_NONE);
        drive_sym(1'b1, COM, 1'b1, 1'b1, 1'b0, E_NONE);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, DAT, 1'b0, 1'b0, 1'b0, E_NONE);
        enable = 1'b0;
        drive_sym(1'b1, COM, 1'b0, 1'b1, 1'b0, E_NONE);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, DAT, 1'b0, 1'b0, 1'b0, E_NONE);
        enable = 1'b1;
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front(); o_v = obs_q.pop_front(); checks++;
            if (o_v !== e_v) begin
                errors++; $display("FAIL conflict_seq: observed %b expected %b", o_v, e_v);
            end
        end
        checks++;
        if (add_cnt !== exp_add || del_cnt !== exp_del) begin
            errors++;
            $display("FAIL conflict_cnt: observed add=%0d del=%0d expected %0d/%0d",
                     add_cnt, del_cnt, exp_add, exp_del);
        end
    endtask

    task automatic test_back_to_back();
        drive_sym(1'b1, COM, 1'b1, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, COM, 1'b0, 1'b0, 1'b0, E_INS);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, DAT, 1'b0, 1'b0, 1'b0, E_NONE);
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front(); o_v = obs_q.pop_front(); checks++;
            if (o_v !== e_v) begin
                errors++; $display("FAIL back_to_back_seq: observed %b expected %b", o_v, e_v);
            end
        end
        checks++;
        if (add_cnt !== 8'd2) begin
            errors++; $display("FAIL back_to_back_cnt: observed %0d expected 2", add_cnt);
        end
    endtask

    // Idle cycles carry SKP/COM codes to show invalid symbols are ignored
    task automatic test_gaps();
        drive_sym(1'b1, COM, 1'b0, 1'b1, 1'b0, E_NONE);
        drive_sym(1'b0, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b0, COM, 1'b1, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b0, DAT, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b0, E_DEL);
        drive_sym(1'b0, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, DAT, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, COM, 1'b1, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b0, DAT, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b0, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, DAT, 1'b0, 1'b0, 1'b0, E_INS);
        drive_sym(1'b0, DAT, 1'b0, 1'b0, 1'b0, E_NONE);
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front(); o_v = obs_q.pop_front(); checks++;
            if (o_v !== e_v) begin
                errors++; $display("FAIL gaps_seq: observed %b expected %b", o_v, e_v);
            end
        end
        checks++;
        if (add_cnt !== exp_add || del_cnt !== exp_del) begin
            errors++;
            $display("FAIL gaps_cnt: observed add=%0d del=%0d expected %0d/%0d",
                     add_cnt, del_cnt, exp_add, exp_del);
        end
    endtask

    task automatic test_reset_mid_set();
        drive_sym(1'b1, COM, 1'b0, 1'b1, 1'b0, E_NONE);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b1, E_NONE);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, DAT, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, COM, 1'b1, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, SKP, 1'b0, 1'b0, 1'b0, E_NONE);
        drive_sym(1'b1, DAT, 1'b0, 1'b0, 1'b1, E_NONE);
        drive_sym(1'b1, DAT, 1'b0, 1'b0, 1'b0, E_NONE);
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front(); o_v = obs_q.pop_front(); checks++;
            if (o_v !== e_v) begin
                errors++; $display("FAIL reset_mid_seq: observed %b expected %b", o_v, e_v);
            end
        end
        checks++;
        if (add_cnt !== 8'd0 || del_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_cnt: observed add=%0d del=%0d expected 0/0", add_cnt, del_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            drive_sym(1'b1, COM,  1'b0, 1'b1, 1'b0, E_NONE);
            drive_sym(1'b1, SKPN, 1'b0, 1'b0, 1'b0, E_NONE);
            drive_sym(1'b1, SKP,  1'b0, 1'b0, 1'b0, E_DEL);
            drive_sym(1'b1, DAT,  1'b0, 1'b0, 1'b0, E_NONE);
        end
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front(); o_v = obs_q.pop_front(); checks++;
            if (o_v !== e_v) begin
                errors++; $display("FAIL saturation_seq: observed %b expected %b", o_v, e_v);
            end
        end
        checks++;
        if (del_cnt !== 8'd255 || add_cnt !== 8'd0) begin
            errors++;
            $display("FAIL saturation_cnt: observed add=%0d del=%0d expected 0/255", add_cnt, del_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_delete();
        test_insert();
        test_length();
        test_conflict();
        test_back_to_back();
        test_gaps();
        test_reset_mid_set();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
